// File: rtl/vga_draw_pkg.sv
// Shared types and constants for the VGA drawing blocks (rectangle rasteriser, frame-buffer side).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_draw_pkg;

    // Rasteriser control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } draw_state_t;

    // Default visible area used as the clip bound
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    // Pixel colour width, must match the frame-buffer write port
    localparam int FB_COLOR_W = 3;

endpackage

// File: rtl/vga_rect_scan_counter.sv
// Row-major cx/cy slot counter for the rectangle rasteriser, with edge flags for outline decoding.
// Latency: load/advance take effect on the next rising edge; flags are combinational from the count.
// Backpressure: none; advances whenever enable is high.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   load                clears cx and cy to 0 (start of a rectangle)
//   enable              advance one slot (cx first, then cy)
//   w_m1, h_m1          rectangle width-1 and height-1
//   cx, cy              current slot column/row offset
//   first_col, last_col, first_row, last_row  slot lies on that border
//   last_slot           current slot is (w-1, h-1)
module vga_rect_scan_counter
    import vga_draw_pkg::*;
#(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           load,
    input  logic           enable,
    input  logic [X_W-1:0] w_m1,
    input  logic [Y_W-1:0] h_m1,
    output logic [X_W-1:0] cx,
    output logic [Y_W-1:0] cy,
    output logic           first_col,
    output logic           last_col,
    output logic           first_row,
    output logic           last_row,
    output logic           last_slot
);

    // Comparing against w-1/h-1 (rather than counting to w/h) keeps the
    // counters at X_W/Y_W bits even for the largest representable size.
    assign first_col = (cx == '0);
    assign last_col  = (cx == w_m1);
    assign first_row = (cy == '0);
    assign last_row  = (cy == h_m1);
    assign last_slot = last_col && last_row;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cx <= '0;
            cy <= '0;
        end else if (load) begin
            cx <= '0;
            cy <= '0;
        end else if (enable) begin
            if (last_col) begin
                cx <= '0;
                cy <= last_row ? '0 : cy + Y_W'(1);
            end else begin
                cx <= cx + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle rasteriser: one frame-buffer pixel slot per clock, row-major, solid or outline mode.
// Latency: first slot 1 cycle after start acceptance, last at w*h; done pulse at w*h+1, ready again at w*h+2.
// Backpressure: none downstream; start is accepted only while ready=1, otherwise dropped (not queued).
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   start                draw request, taken only when ready=1
//   x_in, y_in           origin column/row
//   w_in, h_in           size in pixels (0 in either dimension draws nothing)
//   color_in             pixel colour
//   outline_in           0 = solid fill, 1 = border pixels only
//   ready                idle and able to accept start
//   plot_enable          frame-buffer write enable (registered)
//   x_out, y_out         pixel coordinate (registered, low X_W/Y_W bits of origin+offset)
//   color_out            pixel colour (registered)
//   done                 one-cycle pulse after the last slot
//
// Build option: define RECT_CLIP_EN to suppress writes outside SCREEN_W x SCREEN_H;
// without it coordinates simply wrap modulo 2^X_W / 2^Y_W.
module vga_rect_fill
    import vga_draw_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOR_W  = FB_COLOR_W,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [X_W-1:0]     x_in,
    input  logic [Y_W-1:0]     y_in,
    input  logic [X_W-1:0]     w_in,
    input  logic [Y_W-1:0]     h_in,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               outline_in,
    output logic               ready,
    output logic               plot_enable,
    output logic [X_W-1:0]     x_out,
    output logic [Y_W-1:0]     y_out,
    output logic [COLOR_W-1:0] color_out,
    output logic               done
);

    // The clip compare is done at X_W+1/Y_W+1 bits, so the screen must fit there.
    if (SCREEN_W < 1 || SCREEN_W > (1 << X_W) || SCREEN_H < 1 || SCREEN_H > (1 << Y_W)) begin : g_bad_screen
        $error("vga_rect_fill: SCREEN_W/SCREEN_H outside the coordinate range");
    end

    draw_state_t state, state_nxt;

    // Request parameters captured at acceptance; later input changes are ignored
    logic [X_W-1:0]     x0_r;
    logic [Y_W-1:0]     y0_r;
    logic [X_W-1:0]     w_r;
    logic [Y_W-1:0]     h_r;
    logic [COLOR_W-1:0] color_r;
    logic               outline_r;

    logic               accept;
    logic               zero_size;
    logic [X_W-1:0]     cx;
    logic [Y_W-1:0]     cy;
    logic               first_col, last_col, first_row, last_row, last_slot;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic               in_bounds;
    logic               on_border;
    logic               plot_ok;

    assign accept    = start && ready;
    assign zero_size = (w_in == '0) || (h_in == '0);

    vga_rect_scan_counter #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_scan (
        .clock     (clock),
        .reset     (reset),
        .load      (accept),
        .enable    (state == SCAN),
        .w_m1      (w_r - X_W'(1)),
        .h_m1      (h_r - Y_W'(1)),
        .cx        (cx),
        .cy        (cy),
        .first_col (first_col),
        .last_col  (last_col),
        .first_row (first_row),
        .last_row  (last_row),
        .last_slot (last_slot)
    );

`ifdef RECT_CLIP_EN
    // Carry bit kept so a coordinate that wrapped is still seen as off-screen
    logic [X_W:0] sum_x;
    logic [Y_W:0] sum_y;

    assign sum_x     = {1'b0, x0_r} + {1'b0, cx};
    assign sum_y     = {1'b0, y0_r} + {1'b0, cy};
    assign pix_x     = sum_x[X_W-1:0];
    assign pix_y     = sum_y[Y_W-1:0];
    assign in_bounds = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));
`else
    assign pix_x     = x0_r + cx;
    assign pix_y     = y0_r + cy;
    assign in_bounds = 1'b1;
`endif

    // Interior slots in outline mode are still consumed, just not written,
    // so draw time never depends on the mode.
    assign on_border = first_col || last_col || first_row || last_row;
    assign plot_ok   = in_bounds && (!outline_r || on_border);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = zero_size ? DONE : SCAN;
            SCAN: if (last_slot) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x0_r      <= '0;
            y0_r      <= '0;
            w_r       <= '0;
            h_r       <= '0;
            color_r   <= '0;
            outline_r <= 1'b0;
        end else if (accept) begin
            x0_r      <= x_in;
            y0_r      <= y_in;
            w_r       <= w_in;
            h_r       <= h_in;
            color_r   <= color_in;
            outline_r <= outline_in;
        end
    end

    // Outputs trail the FSM by one edge: the DONE state registers the done
    // pulse, and ready stays low through that pulse cycle, giving the
    // two-cycle gap between rectangles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready       <= 1'b0;
            plot_enable <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            color_out   <= '0;
            done        <= 1'b0;
        end else begin
            ready       <= (state_nxt == IDLE) && (state != DONE);
            done        <= (state == DONE);
            plot_enable <= 1'b0;
            if (state == SCAN) begin
                plot_enable <= plot_ok;
                x_out       <= pix_x;
                y_out       <= pix_y;
                color_out   <= color_r;
            end
        end
    end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Self-checking bench for vga_rect_fill: expected pixel writes and done times are queued by a
// behavioural model when a rectangle is issued; a monitor pops and compares on every write/done.
module tb_vga_rect_fill;

    localparam int X_W     = 8;
    localparam int Y_W     = 7;
    localparam int COLOR_W = 3;
    localparam int SCR_W   = 160;
    localparam int SCR_H   = 120;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [X_W-1:0]     x_in = '0;
    logic [Y_W-1:0]     y_in = '0;
    logic [X_W-1:0]     w_in = '0;
    logic [Y_W-1:0]     h_in = '0;
    logic [COLOR_W-1:0] color_in = '0;
    logic               outline_in = 1'b0;
    logic               ready;
    logic               plot_enable;
    logic [X_W-1:0]     x_out;
    logic [Y_W-1:0]     y_out;
    logic [COLOR_W-1:0] color_out;
    logic               done;

    vga_rect_fill #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .COLOR_W  (COLOR_W),
        .SCREEN_W (SCR_W),
        .SCREEN_H (SCR_H)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .x_in        (x_in),
        .y_in        (y_in),
        .w_in        (w_in),
        .h_in        (h_in),
        .color_in    (color_in),
        .outline_in  (outline_in),
        .ready       (ready),
        .plot_enable (plot_enable),
        .x_out       (x_out),
        .y_out       (y_out),
        .color_out   (color_out),
        .done        (done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t exp_q[$];
    int   exp_done_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write and every done pulse must match the head of its queue
    always @(negedge clock) begin
        if (!reset) begin
            if (plot_enable) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got (%0d,%0d) c=%0d, expected no write", x_out, y_out, color_out);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    check("pixel_x", int'(x_out), e.x);
                    check("pixel_y", int'(y_out), e.y);
                    check("pixel_color", int'(color_out), e.c);
                end
            end
            if (done) begin
                check("done_plot_low", int'(plot_enable), 0);
                if (exp_done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    check("done_cycle", cyc, exp_done_q.pop_front());
                end
            end
        end
    end

    // Reference: every slot of the w x h box in row-major order, written if it is
    // on the border (outline mode) and on screen (clip build); coordinates wrap.
    task automatic model(input int x, input int y, input int w, input int h, input int c, input int o);
        int  px, py;
        bit  border, vis;
        for (int r = 0; r < h; r++) begin
            for (int k = 0; k < w; k++) begin
                px     = x + k;
                py     = y + r;
                border = (k == 0) || (k == w - 1) || (r == 0) || (r == h - 1);
                vis    = 1'b1;
`ifdef RECT_CLIP_EN
                vis    = (px < SCR_W) && (py < SCR_H);
`endif
                if (vis && (o == 0 || border))
                    exp_q.push_back('{px % (1 << X_W), py % (1 << Y_W), c});
            end
        end
    endtask

    task automatic start_rect(input int x, input int y, input int w, input int h,
                              input int c, input int o, output int t0);
        int budget;
        logic [31:0] v;
        budget = 20;
        while (!ready && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL start_ready_timeout: got ready=0, expected 1");
        end
        v = x; x_in = v[X_W-1:0];
        v = y; y_in = v[Y_W-1:0];
        v = w; w_in = v[X_W-1:0];
        v = h; h_in = v[Y_W-1:0];
        v = c; color_in = v[COLOR_W-1:0];
        outline_in = (o != 0);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        t0 = cyc;
        start = 1'b0;
        // Scramble inputs: only the values present at acceptance may matter
        x_in = X_W'($urandom);
        y_in = Y_W'($urandom);
        w_in = X_W'($urandom);
        h_in = Y_W'($urandom);
        color_in = COLOR_W'($urandom);
        outline_in = 1'($urandom);
        model(x, y, w, h, c, o);
        exp_done_q.push_back(t0 + ((w == 0 || h == 0) ? 1 : w * h + 1));
    endtask

    task automatic finish_rect(input int t0, input int w, input int h);
        int budget;
        int exp_ready;
        budget    = w * h + 20;
        exp_ready = t0 + ((w == 0 || h == 0) ? 2 : w * h + 2);
        while (!ready && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 at cycle %0d, expected 1 at %0d", cyc, exp_ready);
        end else begin
            check("ready_cycle", cyc, exp_ready);
        end
        check("writes_drained", exp_q.size(), 0);
        check("done_drained", exp_done_q.size(), 0);
    endtask

    task automatic draw(input int x, input int y, input int w, input int h, input int c, input int o);
        int t0;
        start_rect(x, y, w, h, c, o, t0);
        finish_rect(t0, w, h);
    endtask

    initial begin
        int t0;
        int w, h;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_ready", int'(ready), 0);
        check("rst_plot", int'(plot_enable), 0);
        check("rst_x", int'(x_out), 0);
        check("rst_y", int'(y_out), 0);
        check("rst_color", int'(color_out), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_release", int'(ready), 1);

        // Directed cases
        draw(10, 20, 3, 2, 5, 0);       // solid fill
        draw(0, 0, 4, 3, 2, 1);         // outline, interior suppressed
        draw(7, 9, 0, 5, 1, 0);         // zero width
        draw(7, 9, 5, 0, 1, 0);         // zero height
        draw(158, 118, 4, 4, 3, 0);     // clip / wrap region
        draw(250, 125, 10, 6, 4, 1);    // wrap in both axes, outline
        draw(5, 5, 1, 1, 7, 1);         // single pixel outline

        // Start pulses while busy are ignored
        start_rect(50, 60, 6, 3, 6, 0, t0);
        repeat (4) @(negedge clock);
        x_in = 8'd1; y_in = 7'd1; w_in = 8'd2; h_in = 7'd2; color_in = 3'd1; outline_in = 1'b0;
        start = 1'b1;
        repeat (2) @(negedge clock);
        start = 1'b0;
        finish_rect(t0, 6, 3);

        // Start during the done pulse cycle (ready=0) is ignored too
        start_rect(20, 30, 2, 2, 2, 0, t0);
        repeat (5) @(negedge clock);
        x_in = 8'd3; y_in = 7'd3; w_in = 8'd3; h_in = 7'd3; color_in = 3'd4;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        finish_rect(t0, 2, 2);

        // Reset in the middle of a 5x5 rectangle
        start_rect(30, 40, 5, 5, 6, 0, t0);
        repeat (3) @(negedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        exp_done_q.delete();
        #1;
        check("midrst_plot", int'(plot_enable), 0);
        check("midrst_x", int'(x_out), 0);
        check("midrst_y", int'(y_out), 0);
        check("midrst_color", int'(color_out), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_ready", int'(ready), 0);
        repeat (2) @(negedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_midscan_reset", int'(ready), 1);
        draw(30, 40, 5, 5, 6, 0);

        // Randomized back-to-back rectangles
        for (int i = 0; i < 40; i++) begin
            w = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
            h = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            draw($urandom_range(0, 255), $urandom_range(0, 127), w, h,
                 $urandom_range(0, 7), $urandom_range(0, 1));
        end

        // Largest rectangle: counters must not overflow
        draw(0, 0, 255, 127, 5, 1);

        // Quiet period: no stray writes or done pulses
        repeat (40) @(negedge clock);
        check("final_writes_drained", exp_q.size(), 0);
        check("final_done_drained", exp_done_q.size(), 0);
        check("final_ready", int'(ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
